// File: rtl/instruction_fetch.sv
// Instruction fetch stage: four-phase I-cache handshake, one-entry output
// buffer toward decode, redirect handling with in-flight discard.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        ic_read_enable,
    output logic [63:0] ic_address,
    input  logic [31:0] ic_data,
    input  logic        ic_send_enable,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    input  logic        id_ready,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQUEST,
        S_RELEASE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [63:0] r_pc;
    logic [63:0] r_req_pc;
    logic        r_discard;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [63:0] r_if_pc;
    logic [31:0] r_fetch_count;

    logic        w_consume;
    logic        w_buf_free;
    logic        w_capture;
    logic        w_drop;
    logic        w_load_req;
    logic [63:0] w_redirect_pc;
    logic [63:0] w_pc_next;

    assign w_consume     = r_if_valid & id_ready;
    assign w_buf_free    = ~r_if_valid | id_ready;
    assign w_redirect_pc = redirect_pc & ~64'h3;

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_drop       = 1'b0;
        w_load_req   = 1'b0;
        unique case (r_state)
            S_BOOT: begin
                w_state_next = S_REQUEST;
                w_load_req   = 1'b1;
            end
            S_REQUEST: begin
                if (ic_send_enable) begin
                    if (redirect_valid || r_discard) begin
                        w_drop       = 1'b1;
                        w_state_next = S_RELEASE;
                    end else if (w_buf_free) begin
                        w_capture    = 1'b1;
                        w_state_next = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                if (!ic_send_enable) begin
                    w_state_next = S_REQUEST;
                    w_load_req   = 1'b1;
                end
            end
            default: w_state_next = S_BOOT;
        endcase
    end

    // A redirect landing on the same edge a new request is launched must
    // launch at the redirect target, not the stale sequential pc.
    always_comb begin
        w_pc_next = r_pc;
        if (redirect_valid)
            w_pc_next = w_redirect_pc;
        else if (w_capture)
            w_pc_next = r_req_pc + 64'd4;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_discard     <= 1'b0;
            r_if_valid    <= 1'b0;
            r_if_instr    <= 32'h0;
            r_if_pc       <= 64'h0;
            r_fetch_count <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_load_req)
                r_req_pc <= w_pc_next;
            if (w_drop)
                r_discard <= 1'b0;
            else if (redirect_valid && r_state == S_REQUEST)
                r_discard <= 1'b1;
            if (redirect_valid)
                r_if_valid <= 1'b0;
            else if (w_capture)
                r_if_valid <= 1'b1;
            else if (w_consume)
                r_if_valid <= 1'b0;
            if (w_capture) begin
                r_if_instr <= ic_data;
                r_if_pc    <= r_req_pc;
            end
            if (w_consume)
                r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign ic_read_enable = (r_state == S_REQUEST);
    assign ic_address     = r_req_pc;
    assign if_valid       = r_if_valid;
    assign if_instr       = r_if_instr;
    assign if_pc          = r_if_pc;
    assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 3-cycle latency cache
// responder that can be overridden by manual handshake driving.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        ic_read_enable;
    logic [63:0] ic_address;
    logic [31:0] ic_data;
    logic        ic_send_enable;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready;
    logic [31:0] fetch_count;

    logic        auto_mode;
    logic        rsp_send;
    logic [31:0] rsp_data;
    int          rsp_cnt;
    logic        man_send;
    logic [31:0] man_data;

    int errors = 0;
    int checks = 0;

    instruction_fetch #(.RESET_PC(64'h0)) dut (
        .clock         (clock),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .ic_read_enable(ic_read_enable),
        .ic_address    (ic_address),
        .ic_data       (ic_data),
        .ic_send_enable(ic_send_enable),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .id_ready      (id_ready),
        .fetch_count   (fetch_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] dat(input logic [63:0] a);
        return a[31:0] + 32'h1234_0013;
    endfunction

    // Cache model: answers on the third cycle of a request and holds
    // its data until the request is withdrawn.
    initial begin
        rsp_send = 1'b0;
        rsp_data = 32'h0;
        rsp_cnt  = 0;
        forever begin
            @(negedge clock);
            if (ic_read_enable) begin
                rsp_cnt = rsp_cnt + 1;
                if (rsp_cnt >= 3) begin
                    rsp_send = 1'b1;
                    rsp_data = dat(ic_address);
                end
            end else begin
                rsp_cnt  = 0;
                rsp_send = 1'b0;
            end
        end
    end

    assign ic_send_enable = auto_mode ? rsp_send : man_send;
    assign ic_data        = auto_mode ? rsp_data : man_data;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!if_valid && n < 30);
        checks++;
        assert (if_valid === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=timeout expected=if_valid", tag);
        end
    endtask

    task automatic wait_re(input string tag, input logic lvl);
        int n;
        n = 0;
        while (ic_read_enable !== lvl && n < 30) begin
            step();
            n++;
        end
        checks++;
        assert (ic_read_enable === lvl) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag,
                   ic_read_enable, lvl);
        end
    endtask

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        id_ready       = 1'b1;
        auto_mode      = 1'b1;
        man_send       = 1'b0;
        man_data       = 32'h0;

        step();
        step();
        chk("rst_re", 64'(ic_read_enable), 64'h0);
        chk("rst_addr", ic_address, 64'h0);
        chk("rst_valid", 64'(if_valid), 64'h0);
        chk("rst_instr", 64'(if_instr), 64'h0);
        chk("rst_pc", if_pc, 64'h0);
        chk("rst_cnt", 64'(fetch_count), 64'h0);

        // Sequential fetch 0,4,8 with a free-running decode
        reset = 1'b1;
        step();
        chk("boot_re", 64'(ic_read_enable), 64'h1);
        chk("boot_addr", ic_address, 64'h0);
        wait_valid("seq0_wait");
        chk("seq0_pc", if_pc, 64'h0);
        chk("seq0_instr", 64'(if_instr), 64'(dat(64'h0)));
        wait_valid("seq1_wait");
        chk("seq1_pc", if_pc, 64'h4);
        chk("seq1_instr", 64'(if_instr), 64'(dat(64'h4)));
        wait_valid("seq2_wait");
        chk("seq2_pc", if_pc, 64'h8);
        chk("seq2_instr", 64'(if_instr), 64'(dat(64'h8)));
        step();
        chk("seq_cnt", 64'(fetch_count), 64'd3);
        chk("seq_drain", 64'(if_valid), 64'h0);

        // Back-pressure: full buffer, cache holding data
        id_ready = 1'b0;
        wait_valid("bp_wait");
        chk("bp_pc", if_pc, 64'hC);
        repeat (8) step();
        chk("bp_re", 64'(ic_read_enable), 64'h1);
        chk("bp_addr", ic_address, 64'h10);
        chk("bp_send", 64'(ic_send_enable), 64'h1);
        chk("bp_valid", 64'(if_valid), 64'h1);
        chk("bp_instr", 64'(if_instr), 64'(dat(64'hC)));
        chk("bp_cnt", 64'(fetch_count), 64'd3);
        id_ready = 1'b1;
        step();
        chk("bp_cap_valid", 64'(if_valid), 64'h1);
        chk("bp_cap_pc", if_pc, 64'h10);
        chk("bp_cap_instr", 64'(if_instr), 64'(dat(64'h10)));
        chk("bp_cap_re", 64'(ic_read_enable), 64'h0);
        chk("bp_cap_cnt", 64'(fetch_count), 64'd4);
        step();
        chk("bp_end_cnt", 64'(fetch_count), 64'd5);
        chk("bp_end_valid", 64'(if_valid), 64'h0);

        // Reset in the middle of a request
        wait_re("mid_rst_req", 1'b1);
        reset = 1'b0;
        step();
        chk("mid_rst_re", 64'(ic_read_enable), 64'h0);
        chk("mid_rst_valid", 64'(if_valid), 64'h0);
        chk("mid_rst_cnt", 64'(fetch_count), 64'h0);
        chk("mid_rst_addr", ic_address, 64'h0);

        // Redirect while the request to 0x8 is in flight
        reset = 1'b1;
        step();
        chk("rd_boot_addr", ic_address, 64'h0);
        wait_valid("rd_w0");
        chk("rd_pc0", if_pc, 64'h0);
        wait_valid("rd_w4");
        chk("rd_pc4", if_pc, 64'h4);
        wait_re("rd_req8", 1'b1);
        chk("rd_addr8", ic_address, 64'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1002;
        step();
        redirect_valid = 1'b0;
        chk("rd_hold_re", 64'(ic_read_enable), 64'h1);
        chk("rd_hold_addr", ic_address, 64'h8);
        wait_re("rd_drop", 1'b0);
        wait_re("rd_newreq", 1'b1);
        chk("rd_new_addr", ic_address, 64'h1000);
        wait_valid("rd_wnew");
        chk("rd_new_pc", if_pc, 64'h1000);
        chk("rd_new_instr", 64'(if_instr), 64'(dat(64'h1000)));
        chk("rd_cnt", 64'(fetch_count), 64'd2);

        // Redirect on the same edge the cache answers
        auto_mode = 1'b0;
        man_send  = 1'b0;
        step();
        chk("rs_re", 64'(ic_read_enable), 64'h1);
        chk("rs_addr", ic_address, 64'h1004);
        chk("rs_cnt", 64'(fetch_count), 64'd3);
        man_send       = 1'b1;
        man_data       = 32'hDEAD_BEEF;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        step();
        redirect_valid = 1'b0;
        chk("rs_nocap", 64'(if_valid), 64'h0);
        chk("rs_release", 64'(ic_read_enable), 64'h0);
        step();
        chk("rs_hold_rel", 64'(ic_read_enable), 64'h0);
        man_send = 1'b0;
        step();
        chk("rs_req_re", 64'(ic_read_enable), 64'h1);
        chk("rs_req_addr", ic_address, 64'h2000);

        // Address wrap past the top of the 64-bit space
        man_send = 1'b1;
        man_data = 32'hCAFE_0001;
        step();
        chk("wr_cap_pc", if_pc, 64'h2000);
        chk("wr_cap_instr", 64'(if_instr), 64'hCAFE_0001);
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        chk("wr_rd_valid", 64'(if_valid), 64'h0);
        chk("wr_rd_cnt", 64'(fetch_count), 64'd4);
        man_send = 1'b0;
        step();
        chk("wr_top_re", 64'(ic_read_enable), 64'h1);
        chk("wr_top_addr", ic_address, 64'hFFFF_FFFF_FFFF_FFFC);
        man_send = 1'b1;
        man_data = 32'h0BAD_F00D;
        step();
        chk("wr_top_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wr_top_instr", 64'(if_instr), 64'h0BAD_F00D);
        man_send = 1'b0;
        step();
        chk("wr_zero_re", 64'(ic_read_enable), 64'h1);
        chk("wr_zero_addr", ic_address, 64'h0);
        chk("wr_cnt", 64'(fetch_count), 64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
